decode_hazard_ctrl: RTL and testbench
=====================================

# decode_hazard_ctrl

Hazard and issue controller for the decode stage of the RISC-V core. It tracks the destination registers of instructions in flight in EX, MEM and WB, and compares them with the decode-stage source registers. From that comparison it drives the decode `stall`, the operand forwarding selects and the decode flush on a taken `jmp`. It also sequences multi-cycle multiply ops occupying EX, and sits between the decode stage registers and the EX stage.

## Interface

Parameters:
- `MUL_LAT`, default 4: number of cycles a multiply occupies EX; legal range 2..15.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `dec_valid`  in  1  decode holds a valid instruction.
- `rs1`, `rs2`, `rd`  in  5 each  decode register indices.
- `rs1v`, `rs2v`, `rdv`  in  1 each  the corresponding index is used.
- `is_load`  in  1  decode instruction is a load.
- `is_mul`  in  1  decode instruction is a multiply/divide class op.
- `jmp`  in  1  taken branch/jump resolved by the instruction in EX.
- `mem_stall`  in  1  data memory not ready; freeze the pipeline.
- `stall`  out  1  hold the PC, fetch and decode registers.
- `issue`  out  1  decode instruction enters EX at the next edge.
- `flush`  out  1  invalidate the fetch/decode contents.
- `fwd_a`, `fwd_b`  out  2 each  operand A/B source: 00 regfile, 01 EX result, 10 MEM result, 11 WB result.
- `ex_busy`  out  1  multiply counter nonzero.

## Operation

Tracker:
- Three entries: EX, MEM, WB. Each holds `{valid, rd, rdv, load}`.
- A bubble is an entry with `valid=0`.

Source match on stage S:
- Condition: `rsXv` & `rsX!=0` & `S.valid` & `S.rdv` & `S.rd==rsX`.
- x0 never matches.

Forwarding:
- `fwd_x` selects the youngest matching stage, in priority EX > MEM > WB.
- If no stage matches, `fwd_x` = 00.

Load-use stall:
- Condition: the EX entry matches either used source and has `EX.load=1`.
- Response: `stall=1`, and a bubble is inserted into EX.

Multiply sequencing:
- When a `is_mul` instruction issues, the counter loads `MUL_LAT-1`.
- While the counter is nonzero:
  - `ex_busy=1` and `stall=1`.
  - EX holds its entry and MEM receives a bubble.
  - WB<=MEM, and the counter decrements by one per unfrozen cycle.
- On the final EX cycle (counter 0) the result is forwardable from EX (01).

Jump:
- `flush = jmp & ~mem_stall & ~ex_busy`.
- When flush is high:
  - The decode instruction is not issued and a bubble enters EX.
  - `flush` overrides `stall`, and `stall` is driven 0.

Memory stall:
- `mem_stall=1` freezes the entire state: tracker and counter.
- Outputs: `stall=1`, `issue=0`, `flush=0`.
- Forwarding selects are still computed from the frozen state.

Output equations:
- `stall = mem_stall | ex_busy | (load-use & ~flush)`, gated to 0 while `rst_n` is low.
- `issue = dec_valid & ~stall & ~flush`.

## Timing

Combinational vs registered:
- `stall`, `issue`, `flush`, `fwd_a`, `fwd_b` are combinational from the decode inputs and the registered state, valid in the same cycle.
- `ex_busy` is registered, being the counter state.

Reset (`rst_n` low, asynchronous):
- All tracker entries are invalid and the counter is 0.
- Outputs: `stall=0`, `issue=0`, `flush=0`, `fwd_a=fwd_b=00`, `ex_busy=0`.
- Reset asserted mid-multiply discards the operation. The first edge after release behaves as an empty pipeline.

Normal edge (no freeze, not busy):
- WB<=MEM, MEM<=EX.
- EX<=the decode entry if `issue`, else a bubble.

Latency and simultaneous events:
- A load-use stall lasts exactly 1 cycle. The next cycle forwards from MEM (10).
- A multiply stalls decode for `MUL_LAT-1` cycles.
- `jmp` together with load-use resolves to flush.
- `jmp` together with `mem_stall` is deferred. EX is frozen, so `jmp` stays held and the flush is applied on the first unfrozen cycle.
- `jmp` while `ex_busy` is ignored; the EX stage must not raise it then.
- `dec_valid=0` issues a bubble, and the tracker still shifts.

## Test plan

- **ALU chain:** `add x5` then `sub` using rs1=x5 on the next cycle -> `fwd_a=01`, `stall=0`. After a one-instruction gap -> `fwd_a=10`. After a two-instruction gap -> `fwd_a=11`.
- **Load-use:** `lw x7` followed by a consumer with rs2=x7 -> `stall=1` for 1 cycle with a bubble issued, then `fwd_b=10`. A consumer with rs2=x0 after `lw x0` -> no stall.
- **Multiply:** `MUL_LAT=4`, `mul x3` issued -> `ex_busy`/`stall` high for 3 cycles and MEM receives bubbles. A dependent rs1=x3 then gets `fwd_a=01` on the counter-0 cycle.
- **Jump:** `jmp=1` with a load-use pending in decode -> `flush=1`, `stall=0`, `issue=0`, and a bubble enters EX. The same with `mem_stall=1` -> `flush=0`, state frozen, and flush follows on the cycle `mem_stall` drops.
- **Reset:** `rst_n` pulled low during the 2nd multiply cycle -> all outputs 0 immediately. After release, a dependent instruction sees `fwd=00`, `stall=0`.
- **Random stream:** 10k random instructions against a reference scoreboard model -> forwarding selects and stall cycles match exactly.

Source files
------------

// File: rtl/decode_hazard_ctrl.sv
// Decode-stage hazard controller: tracks EX/MEM/WB destinations, selects operand
// forwarding, raises load-use and multiply stalls, and flushes decode on a taken jump.
module decode_hazard_ctrl #(
  parameter int MUL_LAT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dec_valid,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic [4:0] rd,
  input  logic       rs1v,
  input  logic       rs2v,
  input  logic       rdv,
  input  logic       is_load,
  input  logic       is_mul,
  input  logic       jmp,
  input  logic       mem_stall,
  output logic       stall,
  output logic       issue,
  output logic       flush,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       ex_busy
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       rdv;
    logic       load;
  } entry_t;

  localparam entry_t     BUBBLE   = {1'b0, 5'd0, 1'b0, 1'b0};
  localparam logic [3:0] MUL_LOAD = 4'(MUL_LAT - 1);

  entry_t     ex_r;
  entry_t     mem_r;
  entry_t     wb_r;
  logic [3:0] cnt_r;

  entry_t     dec_entry_s;
  logic       busy_s;
  logic       load_use_s;
  logic       stall_s;
  logic       issue_s;
  logic       flush_s;
  logic [1:0] fwd_a_s;
  logic [1:0] fwd_b_s;

  // x0 is hardwired to zero, so it never creates a dependency.
  function automatic logic src_match(entry_t e, logic [4:0] rs, logic rsv);
    return rsv && (rs != 5'd0) && e.valid && e.rdv && (e.rd == rs);
  endfunction

  function automatic logic [1:0] fwd_sel(entry_t ex, entry_t mem, entry_t wb,
                                         logic [4:0] rs, logic rsv);
    logic [1:0] sel;
    if (src_match(ex, rs, rsv)) begin
      sel = 2'b01;
    end else if (src_match(mem, rs, rsv)) begin
      sel = 2'b10;
    end else if (src_match(wb, rs, rsv)) begin
      sel = 2'b11;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  assign busy_s      = (cnt_r != 4'd0);
  assign dec_entry_s = {1'b1, rd, rdv, is_load};

  // Operand source selects, youngest producer first.
  always_comb begin
    fwd_a_s = 2'b00;
    fwd_b_s = 2'b00;
    fwd_a_s = fwd_sel(ex_r, mem_r, wb_r, rs1, rs1v);
    fwd_b_s = fwd_sel(ex_r, mem_r, wb_r, rs2, rs2v);
  end

  // Stall / issue / flush decision; a taken jump wins over a load-use stall.
  always_comb begin
    load_use_s = 1'b0;
    flush_s    = 1'b0;
    stall_s    = 1'b0;
    issue_s    = 1'b0;
    if (rst_n) begin
      load_use_s = ex_r.load &&
                   (src_match(ex_r, rs1, rs1v) || src_match(ex_r, rs2, rs2v));
      flush_s    = jmp && !mem_stall && !busy_s;
      stall_s    = mem_stall || busy_s || (load_use_s && !flush_s);
      issue_s    = dec_valid && !stall_s && !flush_s;
    end else begin
      load_use_s = 1'b0;
      flush_s    = 1'b0;
      stall_s    = 1'b0;
      issue_s    = 1'b0;
    end
  end

  // Tracker shift: frozen on mem_stall, EX held with MEM bubbles while a multiply runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_r  <= BUBBLE;
      mem_r <= BUBBLE;
      wb_r  <= BUBBLE;
    end else if (mem_stall) begin
      ex_r  <= ex_r;
      mem_r <= mem_r;
      wb_r  <= wb_r;
    end else if (busy_s) begin
      ex_r  <= ex_r;
      mem_r <= BUBBLE;
      wb_r  <= mem_r;
    end else begin
      wb_r  <= mem_r;
      mem_r <= ex_r;
      ex_r  <= issue_s ? dec_entry_s : BUBBLE;
    end
  end

  // Multiply occupancy counter; zero means EX completes this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 4'd0;
    end else if (mem_stall) begin
      cnt_r <= cnt_r;
    end else if (busy_s) begin
      cnt_r <= cnt_r - 4'd1;
    end else if (issue_s && is_mul) begin
      cnt_r <= MUL_LOAD;
    end else begin
      cnt_r <= 4'd0;
    end
  end

  assign stall   = stall_s;
  assign issue   = issue_s;
  assign flush   = flush_s;
  assign fwd_a   = fwd_a_s;
  assign fwd_b   = fwd_b_s;
  assign ex_busy = busy_s;

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Bench for decode_hazard_ctrl: directed hazard scenarios followed by a random
// instruction stream, all checked against a timeline-based pipeline model.
module tb_decode_hazard_ctrl;

  localparam int MUL_LAT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dec_valid = 1'b0;
  logic [4:0] rs1 = 5'd0, rs2 = 5'd0, rd = 5'd0;
  logic       rs1v = 1'b0, rs2v = 1'b0, rdv = 1'b0;
  logic       is_load = 1'b0, is_mul = 1'b0, jmp = 1'b0, mem_stall = 1'b0;
  logic       stall, issue, flush, ex_busy;
  logic [1:0] fwd_a, fwd_b;

  int total = 0;
  int bad   = 0;

  decode_hazard_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid),
    .rs1(rs1), .rs2(rs2), .rd(rd), .rs1v(rs1v), .rs2v(rs2v), .rdv(rdv),
    .is_load(is_load), .is_mul(is_mul), .jmp(jmp), .mem_stall(mem_stall),
    .stall(stall), .issue(issue), .flush(flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .ex_busy(ex_busy)
  );

  always #5 clk = ~clk;

  // Each issued instruction occupies EX over model cycles [s, e]; it is in MEM
  // at cycle e+1 and in WB at e+2. Model time only advances on unfrozen edges.
  typedef struct {
    logic [4:0] rd;
    logic       rdv;
    logic       ld;
    int         s;
    int         e;
  } rec_t;

  rec_t q[$];
  int   mt = 0;
  logic e_stall, e_issue, e_flush, e_busy;
  logic [1:0] e_fa, e_fb;

  function automatic bit hit(rec_t r, bit ok, logic [4:0] rs, logic v);
    return ok && v && (rs != 5'd0) && r.rdv && (r.rd == rs);
  endfunction

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_eval();
    rec_t st[3];
    bit   ok[3];
    bit   lu;
    if (!rst_n) q.delete();
    for (int k = 0; k < 3; k++) ok[k] = 1'b0;
    foreach (q[i]) begin
      if (q[i].s <= mt && mt <= q[i].e) begin st[0] = q[i]; ok[0] = 1'b1; end
      if (q[i].e == mt - 1) begin st[1] = q[i]; ok[1] = 1'b1; end
      if (q[i].e == mt - 2) begin st[2] = q[i]; ok[2] = 1'b1; end
    end
    e_fa = 2'b00;
    e_fb = 2'b00;
    for (int k = 2; k >= 0; k--) begin
      if (hit(st[k], ok[k], rs1, rs1v)) e_fa = 2'(k + 1);
      if (hit(st[k], ok[k], rs2, rs2v)) e_fb = 2'(k + 1);
    end
    e_busy  = ok[0] && (mt < st[0].e);
    lu      = ok[0] && st[0].ld && (hit(st[0], 1'b1, rs1, rs1v) || hit(st[0], 1'b1, rs2, rs2v));
    e_flush = rst_n && jmp && !mem_stall && !e_busy;
    e_stall = rst_n && (mem_stall || e_busy || (lu && !e_flush));
    e_issue = rst_n && dec_valid && !e_stall && !e_flush;
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      q.delete();
    end else if (!mem_stall) begin
      if (e_issue)
        q.push_back('{rd, rdv, is_load, mt + 1, mt + 1 + (is_mul ? MUL_LAT - 1 : 0)});
      mt++;
      while (q.size() > 0 && q[0].e < mt - 2) void'(q.pop_front());
    end
  endtask

  task automatic apply(input logic r, input logic dv,
                       input logic [4:0] a, input logic av,
                       input logic [4:0] b, input logic bv,
                       input logic [4:0] d, input logic dvl,
                       input logic ld, input logic ml, input logic j, input logic ms);
    @(negedge clk);
    rst_n = r; dec_valid = dv; rs1 = a; rs1v = av; rs2 = b; rs2v = bv;
    rd = d; rdv = dvl; is_load = ld; is_mul = ml; jmp = j; mem_stall = ms;
    #1;
    model_eval();
    check("m_stall", {1'b0, stall}, {1'b0, e_stall});
    check("m_issue", {1'b0, issue}, {1'b0, e_issue});
    check("m_flush", {1'b0, flush}, {1'b0, e_flush});
    check("m_busy",  {1'b0, ex_busy}, {1'b0, e_busy});
    check("m_fwd_a", fwd_a, e_fa);
    check("m_fwd_b", fwd_b, e_fb);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
  endtask

  initial begin
    // reset with jmp and mem_stall driven high: every output must stay 0
    apply(1'b0, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    check("rst_stall", {1'b0, stall}, 2'b00);
    check("rst_issue", {1'b0, issue}, 2'b00);
    check("rst_flush", {1'b0, flush}, 2'b00);
    check("rst_fwd_a", fwd_a, 2'b00);
    check("rst_busy",  {1'b0, ex_busy}, 2'b00);
    tick();
    apply(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();

    // ALU chain on x5 at distances 1, 2, 3
    apply(1'b1, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("add_issue", {1'b0, issue}, 2'b01); tick();
    apply(1'b1, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("chain_ex", fwd_a, 2'b01); check("chain_ex_stall", {1'b0, stall}, 2'b00); tick();
    apply(1'b1, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("chain_mem", fwd_a, 2'b10); tick();
    apply(1'b1, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("chain_wb", fwd_a, 2'b11); tick();

    // load-use on x7: one stall cycle, then forwarded from MEM
    apply(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    apply(1'b1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lu_stall", {1'b0, stall}, 2'b01); check("lu_issue", {1'b0, issue}, 2'b00); tick();
    apply(1'b1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lu_release", {1'b0, stall}, 2'b00); check("lu_fwd_b", fwd_b, 2'b10); tick();
    // load to x0 never creates a hazard
    apply(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    apply(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("x0_stall", {1'b0, stall}, 2'b00); check("x0_fwd_b", fwd_b, 2'b00); tick();

    // multiply on x3: three busy cycles with MEM bubbles, then EX forward
    apply(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("mul_issue", {1'b0, issue}, 2'b01); tick();
    for (int c = 0; c < 3; c++) begin
      apply(1'b1, 1'b1, 5'd3, 1'b1, 5'd11, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check("mul_busy", {1'b0, ex_busy}, 2'b01);
      check("mul_stall", {1'b0, stall}, 2'b01);
      check("mul_bubble_fwd_b", fwd_b, (c == 0) ? 2'b10 : (c == 1) ? 2'b11 : 2'b00);
      tick();
    end
    apply(1'b1, 1'b1, 5'd3, 1'b1, 5'd11, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("mul_done_busy", {1'b0, ex_busy}, 2'b00);
    check("mul_done_stall", {1'b0, stall}, 2'b00);
    check("mul_done_fwd_a", fwd_a, 2'b01); tick();

    // reset asserted during the second multiply cycle
    apply(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    apply(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("mul2_busy", {1'b0, ex_busy}, 2'b01); tick();
    apply(1'b0, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    check("mrst_busy", {1'b0, ex_busy}, 2'b00); check("mrst_stall", {1'b0, stall}, 2'b00);
    check("mrst_flush", {1'b0, flush}, 2'b00); check("mrst_fwd_a", fwd_a, 2'b00); tick();
    apply(1'b1, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("post_rst_fwd_a", fwd_a, 2'b00); check("post_rst_stall", {1'b0, stall}, 2'b00);
    check("post_rst_issue", {1'b0, issue}, 2'b01); tick();

    // jump while a load-use is pending: flush wins
    apply(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    apply(1'b1, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("jlu_flush", {1'b0, flush}, 2'b01); check("jlu_stall", {1'b0, stall}, 2'b00);
    check("jlu_issue", {1'b0, issue}, 2'b00); tick();
    apply(1'b1, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("jlu_after_fwd_a", fwd_a, 2'b10); check("jlu_after_stall", {1'b0, stall}, 2'b00); tick();

    // jump during mem_stall is deferred to the first unfrozen cycle
    apply(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    apply(1'b1, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd15, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    check("jms_flush", {1'b0, flush}, 2'b00); check("jms_stall", {1'b0, stall}, 2'b01);
    check("jms_issue", {1'b0, issue}, 2'b00); tick();
    apply(1'b1, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd15, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("jms_late_flush", {1'b0, flush}, 2'b01); check("jms_frozen_fwd_a", fwd_a, 2'b01); tick();
    apply(1'b1, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("jms_after_fwd_a", fwd_a, 2'b10); tick();

    // random instruction stream
    for (int n = 0; n < 10000; n++) begin
      logic ml;
      ml = ($urandom_range(0, 9) == 0);
      apply($urandom_range(0, 599) != 0, $urandom_range(0, 9) != 0,
            5'($urandom_range(0, 4)), $urandom_range(0, 4) != 0,
            5'($urandom_range(0, 4)), $urandom_range(0, 4) != 0,
            5'($urandom_range(0, 4)), $urandom_range(0, 4) != 0,
            !ml && ($urandom_range(0, 3) == 0), ml,
            $urandom_range(0, 11) == 0, $urandom_range(0, 7) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
